axi_edge_counter: RTL and testbench
===================================

// Module: axi_edge_counter
// PURPOSE
//  Gated edge counter on the 1-bit signal selected by the AXI-controlled source mux (mux dout -> sig_in).
//  Software programs a gate length and starts a window; the block counts rising or falling edges of
//  sig_in over exactly GATE clocks, latches the result and raises DONE/irq. Own AXI4-Lite slave, same bus
//  flavour as the mux (16-bit address, 32-bit data), so both sit side by side on one interconnect.
// PARAMETERS
//  C_SYNC_STAGES  2  synchronizer flops on sig_in (legal 2..4)
//  C_CNT_W        32 edge counter / result width (legal 8..32; registers zero-extend to 32)
// PORTS
//  s_axi_aclk     in  1   single clock for all logic
//  s_axi_aresetn  in  1   reset, synchronous, active-low
//  s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave: awaddr/araddr 16, wdata/rdata 32, wstrb 4, bresp/rresp 2, awprot/arprot 3 (ignored)
//  sig_in         in  1   asynchronous monitored signal (mux output)
//  irq            out 1   level interrupt = STATUS.DONE & CTRL.IRQ_EN
// BEHAVIOUR
//  Registers (byte addr, awaddr[4:2] decoded, upper bits ignored; unmapped: read 0, write dropped, resp OKAY):
//   0x00 CTRL  rw: [0] START (write-1 pulse, reads 0) [1] CONT [2] EDGE_SEL (0 rise,1 fall) [3] IRQ_EN [4] ABORT (pulse, reads 0)
//   0x04 STAT  [0] BUSY ro [1] DONE w1c [2] OVF w1c
//   0x08 GATE  rw, gate length in clocks, reset 0
//   0x0C RESULT ro, last completed count;  0x10 LIVE ro, running count
//  wstrb honoured per byte on CTRL/GATE; w1c bits need wstrb[0].
//  AXI write: awready=wready=1 for one cycle when awvalid&wvalid&!bvalid; bvalid set next cycle, held until bready.
//   Write with only one of awvalid/wvalid present waits; no outstanding >1. bresp/rresp always 2'b00.
//  AXI read: arready=1 one cycle when arvalid&!rvalid; rvalid+rdata next cycle, rdata stable until rvalid&rready.
//  Reset values: all ready/valid outputs 0, rdata 0, irq 0, all registers 0, FSM IDLE, sync chain 0.
//  Input path: C_SYNC_STAGES flops + 1 history flop; edge = (s_last ^ s_prev) filtered by EDGE_SEL.
//   sig_in transition is counted no earlier than C_SYNC_STAGES+1 clocks after it is sampled.
//  FSM: IDLE -> (START & GATE!=0) -> ARM -> COUNT -> LATCH -> IDLE, or -> ARM if CONT.
//   IDLE : BUSY=0. START with GATE==0 ignored (no DONE).
//   ARM  : 1 cycle; LIVE<=0, timer<=GATE-1, BUSY=1; edges in this cycle not counted.
//   COUNT: each cycle LIVE+=edge; timer-- ; leaves when timer==0 (edge in that cycle counted) -> exactly GATE cycles.
//   LATCH: 1 cycle; RESULT<=LIVE, DONE<=1 (set wins over same-cycle w1c). CONT=1 -> ARM, else IDLE.
//  LIVE saturates at 2^C_CNT_W-1; increment attempted at max sets OVF (sticky until w1c).
//  START while BUSY ignored. ABORT any state -> IDLE next cycle, RESULT/DONE unchanged, LIVE keeps value.
//  ABORT and START in same write: ABORT wins. Clearing CONT mid-window: current window completes, then IDLE.
//  GATE writes during a window take effect at next ARM. Reset mid-window: everything to reset values.
//  irq updates one cycle after DONE or IRQ_EN changes (registered).
// TESTING
//  1. Reset, read all regs -> 0; irq=0; unmapped 0x1C read -> 0, OKAY.
//  2. GATE=100, EDGE_SEL=0, 10 clean pulses (5 hi/5 lo) inside window, START -> RESULT=10, DONE=1, BUSY 0 after 102 clocks.
//  3. Same pulses, EDGE_SEL=1, pulse straddling gate end -> only edges in 100-cycle window counted (exact count checked vs model).
//  4. C_CNT_W=8, GATE=1000, sig_in toggling every clock -> LIVE sticks 255, OVF=1; w1c STAT=0x6 -> DONE,OVF 0.
//  5. CONT=1, IRQ_EN=1, GATE=20 -> LATCH every 22 clocks, irq high; clear CONT -> one more RESULT then IDLE.
//  6. AXI: aw then w 3 clocks later, bready held low 5 clocks -> single write, bvalid held; ABORT mid-window -> BUSY 0, RESULT unchanged.

Source files
------------

// File: rtl/axi_edge_counter.sv
// ---------------------------------------------------------------------------
// axi_edge_counter
//
// Gated edge counter on a single asynchronous input. Software programs a
// gate length (in clocks) and starts a window; the block counts rising or
// falling edges of sig_in for exactly GATE clocks, latches the count into
// RESULT and raises STATUS.DONE (and irq when enabled). Continuous mode
// re-arms a new window right after each latch.
//
// Ports
//   s_axi_aclk / s_axi_aresetn : clock, synchronous active-low reset
//   s_axi_aw* / w* / b*        : AXI4-Lite write channels (16-bit addr, 32-bit data)
//   s_axi_ar* / r*             : AXI4-Lite read channels
//   sig_in                     : asynchronous monitored signal
//   irq                        : level interrupt, registered DONE & IRQ_EN
//
// Register map (word index = addr[4:2])
//   0x00 CTRL   [0] START pulse [1] CONT [2] EDGE_SEL [3] IRQ_EN [4] ABORT pulse
//   0x04 STAT   [0] BUSY ro  [1] DONE w1c  [2] OVF w1c
//   0x08 GATE   gate length in clocks
//   0x0C RESULT last completed count
//   0x10 LIVE   running count
// ---------------------------------------------------------------------------
module axi_edge_counter #(
  parameter int C_SYNC_STAGES = 2,
  parameter int C_CNT_W       = 32
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [15:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [15:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        sig_in,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  localparam logic [C_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [C_CNT_W-1:0] CNT_ONE = C_CNT_W'(1);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STAT   = 3'd1;
  localparam logic [2:0] REG_GATE   = 3'd2;
  localparam logic [2:0] REG_RESULT = 3'd3;
  localparam logic [2:0] REG_LIVE   = 3'd4;

  // Bus handshake state
  logic        wr_ready;
  logic        bvalid;
  logic        ar_ready;
  logic        rvalid;
  logic [31:0] rdata;

  // Software-visible registers
  logic               cont;
  logic               edge_sel;
  logic               irq_en;
  logic               done;
  logic               ovf;
  logic [31:0]        gate;
  logic [C_CNT_W-1:0] result;
  logic [C_CNT_W-1:0] live;

  // Window engine
  logic [1:0]  state;
  logic [31:0] timer;
  logic        busy;

  // Input conditioning
  logic [C_SYNC_STAGES-1:0] sync_q;
  logic                     s_last;
  logic                     s_prev;
  logic                     edge_hit;

  // Decoded write strobes
  logic wr_en;
  logic wr_ctrl;
  logic wr_stat;
  logic wr_gate;
  logic start_req;
  logic abort_req;
  logic clr_done;
  logic clr_ovf;

  logic [31:0] rd_mux;
  logic [31:0] result_ext;
  logic [31:0] live_ext;

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[15:5], s_axi_awaddr[1:0],
                         s_axi_araddr[15:5], s_axi_araddr[1:0]};

  assign s_axi_awready = wr_ready;
  assign s_axi_wready  = wr_ready;
  assign s_axi_bvalid  = bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = ar_ready;
  assign s_axi_rvalid  = rvalid;
  assign s_axi_rdata   = rdata;
  assign s_axi_rresp   = 2'b00;

  // A write is accepted only when both address and data are present, so a
  // master that presents them on different cycles simply waits.
  assign wr_en     = wr_ready & s_axi_awvalid & s_axi_wvalid;
  assign wr_ctrl   = wr_en && (s_axi_awaddr[4:2] == REG_CTRL);
  assign wr_stat   = wr_en && (s_axi_awaddr[4:2] == REG_STAT);
  assign wr_gate   = wr_en && (s_axi_awaddr[4:2] == REG_GATE);
  assign start_req = wr_ctrl & s_axi_wstrb[0] & s_axi_wdata[0];
  assign abort_req = wr_ctrl & s_axi_wstrb[0] & s_axi_wdata[4];
  assign clr_done  = wr_stat & s_axi_wstrb[0] & s_axi_wdata[1];
  assign clr_ovf   = wr_stat & s_axi_wstrb[0] & s_axi_wdata[2];

  assign busy = (state != ST_IDLE);

  // Write channel: one-cycle ready pulse, response held until bready.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_ready <= 1'b0;
      bvalid   <= 1'b0;
    end else begin
      wr_ready <= !wr_ready && s_axi_awvalid && s_axi_wvalid && !bvalid;
      if (wr_en) begin
        bvalid <= 1'b1;
      end else if (bvalid && s_axi_bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Plain read/write configuration registers with byte enables.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      cont     <= 1'b0;
      edge_sel <= 1'b0;
      irq_en   <= 1'b0;
      gate     <= '0;
    end else begin
      if (wr_ctrl && s_axi_wstrb[0]) begin
        cont     <= s_axi_wdata[1];
        edge_sel <= s_axi_wdata[2];
        irq_en   <= s_axi_wdata[3];
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_gate && s_axi_wstrb[b]) begin
          gate[8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Synchronizer plus one history flop; the edge is judged between the
  // last synchronized sample and the one before it.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], sig_in};
      s_prev <= s_last;
    end
  end

  assign s_last   = sync_q[C_SYNC_STAGES-1];
  assign edge_hit = edge_sel ? (s_prev & ~s_last) : (~s_prev & s_last);

  // Window engine. The w1c clears come first so that a same-cycle set from
  // LATCH or a saturating increment overrides them. ABORT skips the state
  // work entirely, leaving LIVE, RESULT and DONE untouched.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state  <= ST_IDLE;
      timer  <= '0;
      live   <= '0;
      result <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (clr_done) done <= 1'b0;
      if (clr_ovf)  ovf  <= 1'b0;
      if (abort_req) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req && (gate != 32'd0)) state <= ST_ARM;
          end
          ST_ARM: begin
            live  <= '0;
            timer <= gate - 32'd1;
            state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (edge_hit) begin
              if (live == CNT_MAX) ovf <= 1'b1;
              else                 live <= live + CNT_ONE;
            end
            timer <= timer - 32'd1;
            if (timer == 32'd0) state <= ST_LATCH;
          end
          ST_LATCH: begin
            result <= live;
            done   <= 1'b1;
            state  <= cont ? ST_ARM : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) irq <= 1'b0;
    else                irq <= done & irq_en;
  end

  always_comb begin
    result_ext = '0;
    live_ext   = '0;
    result_ext[C_CNT_W-1:0] = result;
    live_ext[C_CNT_W-1:0]   = live;
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[4:2])
      REG_CTRL:   rd_mux = {28'd0, irq_en, edge_sel, cont, 1'b0};
      REG_STAT:   rd_mux = {29'd0, ovf, done, busy};
      REG_GATE:   rd_mux = gate;
      REG_RESULT: rd_mux = result_ext;
      REG_LIVE:   rd_mux = live_ext;
      default:    rd_mux = '0;
    endcase
  end

  // Read channel: data is captured at the address handshake and held until
  // the master takes it.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      ar_ready <= !ar_ready && s_axi_arvalid && !rvalid;
      if (ar_ready && s_axi_arvalid) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (rvalid && s_axi_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_edge_counter.sv
// ---------------------------------------------------------------------------
// tb_axi_edge_counter
//
// Two instances share every input: a 32-bit counter and an 8-bit counter
// (so saturation is reachable). Reads push their expected value into a
// queue; a monitor pops and compares whenever a read response appears.
// ---------------------------------------------------------------------------
module tb_axi_edge_counter;

  localparam logic [15:0] A_CTRL   = 16'h0000;
  localparam logic [15:0] A_STAT   = 16'h0004;
  localparam logic [15:0] A_GATE   = 16'h0008;
  localparam logic [15:0] A_RESULT = 16'h000C;
  localparam logic [15:0] A_LIVE   = 16'h0010;
  localparam logic [15:0] A_UNMAP  = 16'h001C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn = 1'b0;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b1;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b1;
  logic        sig_in = 1'b0;

  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic        awready8, wready8, bvalid8, arready8, rvalid8, irq8;
  logic [1:0]  bresp8, rresp8;
  logic [31:0] rdata8;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [31:0] exp_q[$];
  bit          sel_q[$];
  string       name_q[$];

  axi_edge_counter #(.C_SYNC_STAGES(2), .C_CNT_W(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .sig_in(sig_in), .irq(irq)
  );

  axi_edge_counter #(.C_SYNC_STAGES(2), .C_CNT_W(8)) dut8 (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready8),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready8),
    .s_axi_bresp(bresp8), .s_axi_bvalid(bvalid8), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready8),
    .s_axi_rdata(rdata8), .s_axi_rresp(rresp8), .s_axi_rvalid(rvalid8), .s_axi_rready(rready),
    .sig_in(sig_in), .irq(irq8)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    logic [31:0] got_v;
    bit          sel_v;
    string       nm;
    if (aresetn === 1'b1 && rvalid === 1'b1 && rready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, expected no response", rdata);
      end else begin
        exp_v = exp_q.pop_front();
        sel_v = sel_q.pop_front();
        nm    = name_q.pop_front();
        got_v = sel_v ? rdata8 : rdata;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, got_v, exp_v);
        end
      end
      vectors++;
      if (rresp !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL rresp: got %0d, expected 0", rresp);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic failTimeout(input string nm);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out, expected handshake", nm);
  endtask

  task automatic axiWrite(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) failTimeout("write_ready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) failTimeout("write_resp");
    else checkOutput("bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axiRead(input logic [15:0] a, input logic [31:0] exp, input bit sel, input string nm);
    int n;
    exp_q.push_back(exp); sel_q.push_back(sel); name_q.push_back(nm);
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) failTimeout({nm, "_arready"});
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) failTimeout({nm, "_rvalid"});
    @(posedge clk); #1;
  endtask

  // Clean pulses on sig_in, each hi clocks high then lo clocks low.
  task automatic applyStimulus(input int pulses, input int hi, input int lo);
    for (int k = 0; k < pulses; k++) begin
      sig_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      sig_in = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIrq(input logic level, input int limit, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (irq !== level && n < limit) begin @(negedge clk); n++; end
    if (irq !== level) failTimeout(nm);
  endtask

  initial begin
    int r1;
    int r2;
    int n;

    // Reset values, unmapped read, GATE==0 start ignored
    repeat (5) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
    axiRead(A_CTRL,   32'h0, 0, "reset_ctrl");
    axiRead(A_STAT,   32'h0, 0, "reset_stat");
    axiRead(A_GATE,   32'h0, 0, "reset_gate");
    axiRead(A_RESULT, 32'h0, 0, "reset_result");
    axiRead(A_LIVE,   32'h0, 0, "reset_live");
    axiRead(A_UNMAP,  32'h0, 0, "unmapped_read");
    axiWrite(A_CTRL, 32'h1, 4'hF);
    axiRead(A_STAT,   32'h0, 0, "gate0_start_ignored");

    // Rising edges: 10 pulses fully inside a 100-clock window
    axiWrite(A_GATE, 32'd100, 4'hF);
    axiWrite(A_CTRL, 32'h1, 4'hF);
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(10, 5, 5);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        axiRead(A_STAT, 32'h1, 0, "busy_mid_window");
      end
    join
    axiRead(A_STAT,   32'h2, 0, "rise_stat_done");
    axiRead(A_RESULT, 32'd10, 0, "rise_result");
    axiRead(A_LIVE,   32'd10, 0, "rise_live");
    axiRead(A_RESULT, 32'd10, 1, "rise_result_w8");
    checkOutput("irq_disabled", 32'(irq), 32'd0);

    // Falling edges: 9 pulses inside, then one pulse whose fall lands
    // after the window closes
    axiWrite(A_STAT, 32'h2, 4'h1);
    axiWrite(A_CTRL, 32'h5, 4'hF);
    applyStimulus(9, 5, 5);
    sig_in = 1'b1;
    repeat (20) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    axiRead(A_STAT,   32'h2, 0, "fall_stat_done");
    axiRead(A_RESULT, 32'd9, 0, "fall_result");
    axiRead(A_LIVE,   32'd9, 0, "fall_live");
    axiRead(A_CTRL,   32'h4, 0, "ctrl_readback");

    // Byte strobes
    axiWrite(A_CTRL, 32'h8, 4'h2);
    axiRead(A_CTRL, 32'h4, 0, "ctrl_strobe_ignored");
    axiWrite(A_GATE, 32'h12345678, 4'hF);
    axiWrite(A_GATE, 32'hAABBCCDD, 4'h5);
    axiRead(A_GATE, 32'h12BB56DD, 0, "gate_byte_strobe");

    // Address before data, then a stalled response
    awaddr = A_GATE; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("aw_alone_no_ready", 32'(awready), 32'd0);
    end
    @(posedge clk); #1;
    wdata = 32'd200; wstrb = 4'hF; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) failTimeout("split_write_ready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bvalid_held", 32'(bvalid), 32'd1);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bvalid_released", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    axiRead(A_GATE, 32'd200, 0, "split_write_gate");

    // Abort mid-window: RESULT and DONE keep their values, LIVE freezes
    axiWrite(A_CTRL, 32'h1, 4'hF);
    applyStimulus(3, 5, 5);
    repeat (20) @(posedge clk);
    #1;
    axiWrite(A_CTRL, 32'h10, 4'hF);
    axiRead(A_STAT,   32'h2, 0, "abort_stat");
    axiRead(A_RESULT, 32'd9, 0, "abort_result_kept");
    axiRead(A_LIVE,   32'd3, 0, "abort_live_kept");
    axiWrite(A_CTRL, 32'h11, 4'hF);
    axiRead(A_STAT,   32'h2, 0, "abort_beats_start");

    // Continuous mode with interrupts, 20-clock gate -> latch every 22
    axiWrite(A_STAT, 32'h2, 4'h1);
    axiWrite(A_GATE, 32'd20, 4'hF);
    axiWrite(A_CTRL, 32'hB, 4'hF);
    waitIrq(1'b1, 100, "cont_irq_first");
    r1 = cycle;
    axiWrite(A_STAT, 32'h2, 4'h1);
    waitIrq(1'b0, 10, "cont_irq_cleared");
    waitIrq(1'b1, 50, "cont_irq_second");
    r2 = cycle;
    checkOutput("cont_period", 32'(r2 - r1), 32'd22);
    axiWrite(A_CTRL, 32'h8, 4'hF);
    axiRead(A_STAT, 32'h3, 0, "cont_busy_done");
    axiWrite(A_STAT, 32'h2, 4'h1);
    repeat (60) @(posedge clk);
    #1;
    axiRead(A_STAT, 32'h2, 0, "cont_last_window");
    checkOutput("irq_level", 32'(irq), 32'd1);
    axiWrite(A_CTRL, 32'h0, 4'hF);
    checkOutput("irq_follows_en", 32'(irq), 32'd0);
    axiWrite(A_STAT, 32'h2, 4'h1);
    repeat (40) @(posedge clk);
    #1;
    axiRead(A_STAT, 32'h0, 0, "cont_stopped");

    // Saturation on the 8-bit instance: ~500 rising edges in 1000 clocks
    axiWrite(A_GATE, 32'd1000, 4'hF);
    axiWrite(A_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 1010; i++) begin
      sig_in = ~sig_in;
      @(posedge clk);
      #1;
    end
    sig_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    axiRead(A_STAT,   32'h6, 1, "sat_stat_w8");
    axiRead(A_LIVE,   32'hFF, 1, "sat_live_w8");
    axiRead(A_RESULT, 32'hFF, 1, "sat_result_w8");
    axiRead(A_STAT,   32'h2, 0, "no_ovf_w32");
    axiWrite(A_STAT, 32'h6, 4'h2);
    axiRead(A_STAT,   32'h6, 1, "w1c_needs_strb0");
    axiWrite(A_STAT, 32'h6, 4'h1);
    axiRead(A_STAT,   32'h0, 1, "w1c_clears_w8");

    // Reset in the middle of a window
    axiWrite(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(posedge clk);
    #1 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    axiRead(A_GATE,   32'h0, 0, "midreset_gate");
    axiRead(A_STAT,   32'h0, 0, "midreset_stat");
    axiRead(A_RESULT, 32'h0, 1, "midreset_result_w8");
    checkOutput("midreset_irq", 32'(irq), 32'd0);

    repeat (5) @(posedge clk);
    while (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got no response, expected 0x%08h", name_q.pop_front(), exp_q.pop_front());
      void'(sel_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
